alu_req_arbiter: RTL and testbench

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

---
 rtl/alu_req_arbiter_pkg.sv | 8 +
 rtl/alu_req_arbiter_two_bit_alu.sv | 19 +
 rtl/alu_req_arbiter.sv | 58 +++++
 tb/tb_alu_req_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/alu_req_arbiter_pkg.sv
// alu_req_arbiter_pkg: op-code constants and state encoding shared by the arbiter and its ALU
package alu_req_arbiter_pkg;
   localparam logic [1:0] OP_ZERO = 2'b00;
   localparam logic [1:0] OP_ADD  = 2'b01;
   localparam logic [1:0] OP_SUB  = 2'b10;
   localparam logic [1:0] OP_MUL  = 2'b11;
   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/alu_req_arbiter_two_bit_alu.sv
// Two_bit_ALU: combinational 2-bit ALU with a 4-bit result; subtraction wraps modulo 16
module Two_bit_ALU
   import alu_req_arbiter_pkg::*;
(
   input  logic [1:0] op,
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [3:0] result
);
   logic [3:0] xw, yw;
   assign xw = {2'b00, x};
   assign yw = {2'b00, y};
   // Select the operation; OP_ZERO yields zero
   always_comb begin
      result = (op == OP_ADD) ? xw + yw :
               (op == OP_SUB) ? xw - yw :
               (op == OP_MUL) ? xw * yw : 4'd0;
   end
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin arbiter sharing one 2-bit ALU between two requesters, one registered response slot
module alu_req_arbiter
   import alu_req_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid_0,
   input  logic [1:0] req_op_0,
   input  logic [1:0] req_x_0,
   input  logic [1:0] req_y_0,
   output logic       req_ready_0,
   input  logic       req_valid_1,
   input  logic [1:0] req_op_1,
   input  logic [1:0] req_x_1,
   input  logic [1:0] req_y_1,
   output logic       req_ready_1,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [3:0] rsp_data,
   output logic       rsp_id,
   output logic [7:0] op_count
);
   state_t     state, state_nx;
   logic       rr_ptr, gnt, gnt_id;
   logic [1:0] alu_op, alu_x, alu_y;
   logic [3:0] alu_res;
   Two_bit_ALU u_alu (.op(alu_op), .x(alu_x), .y(alu_y), .result(alu_res));
   assign rsp_valid = (state == HOLD);
   // Arbitrate when the slot is free or being drained; rr_ptr breaks ties; route the winner to the ALU
   always_comb begin
      gnt         = !rst && (state == IDLE || rsp_ready) && (req_valid_0 || req_valid_1);
      gnt_id      = (req_valid_0 && req_valid_1) ? rr_ptr : req_valid_1;
      req_ready_0 = gnt && !gnt_id;
      req_ready_1 = gnt && gnt_id;
      alu_op      = gnt_id ? req_op_1 : req_op_0;
      alu_x       = gnt_id ? req_x_1  : req_x_0;
      alu_y       = gnt_id ? req_y_1  : req_y_0;
      state_nx    = gnt ? HOLD : (rsp_ready ? IDLE : state);
   end
   // Capture the granted result, advance the pointer, count drained responses saturating at 255
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rsp_data <= 4'd0;
         rsp_id   <= 1'b0;
         rr_ptr   <= 1'b0;
         op_count <= 8'd0;
      end else begin
         state <= state_nx;
         if (gnt) begin
            rsp_data <= alu_res;
            rsp_id   <= gnt_id;
            rr_ptr   <= ~gnt_id;
         end
         if (rsp_valid && rsp_ready && op_count != 8'hFF) op_count <= op_count + 8'd1;
      end
   end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed and randomized checks against a behavioural model of the arbiter
module tb_alu_req_arbiter;
   logic       clk = 0, rst = 1, rsp_ready = 0;
   logic [1:0] v = 0;
   logic [1:0] op [2];
   logic [1:0] x [2];
   logic [1:0] y [2];
   logic       rdy0, rdy1, rsp_valid, rsp_id;
   logic [3:0] rsp_data;
   logic [7:0] op_count;
   int         passed = 0, total = 0;
   bit         m_valid, m_id, m_ptr, mg0, mg1, prev_id;
   int         m_data, m_cnt;

   always #5 clk = ~clk;

   alu_req_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid_0(v[0]), .req_op_0(op[0]), .req_x_0(x[0]), .req_y_0(y[0]), .req_ready_0(rdy0),
      .req_valid_1(v[1]), .req_op_1(op[1]), .req_x_1(x[1]), .req_y_1(y[1]), .req_ready_1(rdy1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
      .op_count(op_count)
   );

   function automatic int ref_alu(int o, int a, int b);
      return o == 1 ? a + b : o == 2 ? (a - b + 16) % 16 : o == 3 ? a * b : 0;
   endfunction

   task automatic chk(string tag, int obs, int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model across the edge
   task automatic cyc();
      bit can, g;
      @(negedge clk);
      can = !rst && (!m_valid || rsp_ready) && (v != 0);
      g   = (v == 2'b11) ? m_ptr : v[1];
      mg0 = can && !g;
      mg1 = can && g;
      chk("ready0", int'(rdy0), int'(mg0));
      chk("ready1", int'(rdy1), int'(mg1));
      chk("rsp_valid", int'(rsp_valid), int'(m_valid));
      chk("rsp_data", int'(rsp_data), m_data);
      chk("rsp_id", int'(rsp_id), int'(m_id));
      chk("op_count", int'(op_count), m_cnt);
      if (rst) begin
         m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
      end else begin
         if (m_valid && rsp_ready && m_cnt < 255) m_cnt++;
         if (can) begin
            m_data  = ref_alu(int'(op[g]), int'(x[g]), int'(y[g]));
            m_id    = g;
            m_ptr   = !g;
            m_valid = 1;
         end else if (rsp_ready) m_valid = 0;
      end
      @(posedge clk); #1;
   endtask

   // Requesters keep a pending request stable until granted, then optionally issue a new one
   task automatic refresh(bit always_valid);
      for (int i = 0; i < 2; i++) begin
         if ((i == 0 ? mg0 : mg1) || !v[i]) begin
            v[i]  = always_valid ? 1'b1 : 1'($urandom_range(0, 1));
            op[i] = 2'($urandom);
            x[i]  = 2'($urandom);
            y[i]  = 2'($urandom);
         end
      end
   endtask

   initial begin
      op[0] = 0; op[1] = 0; x[0] = 0; x[1] = 0; y[0] = 0; y[1] = 0;
      cyc(); cyc();
      rst = 0;
      v[0] = 1; op[0] = 2'b01; x[0] = 2'b01; y[0] = 2'b10;
      cyc();
      v[0] = 0;
      chk("r030_valid", int'(rsp_valid), 1);
      chk("r030_data", int'(rsp_data), 4'b0011);
      chk("r030_id", int'(rsp_id), 0);
      cyc();
      rst = 1; cyc(); rst = 0;
      rsp_ready = 1;
      v = 2'b11;
      op[0] = 2'b11; x[0] = 2'b11; y[0] = 2'b11;
      op[1] = 2'b10; x[1] = 2'b11; y[1] = 2'b01;
      cyc();
      v[0] = 0;
      chk("r031_data0", int'(rsp_data), 4'b1001);
      chk("r031_id0", int'(rsp_id), 0);
      cyc();
      v[1] = 0;
      chk("r031_data1", int'(rsp_data), 4'b0010);
      chk("r031_id1", int'(rsp_id), 1);
      rsp_ready = 0;
      v[1] = 1; op[1] = 2'b11; x[1] = 2'b10; y[1] = 2'b11;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("r032_stall_data", int'(rsp_data), 4'b0010);
         chk("r032_stall_ready1", int'(rdy1), 0);
      end
      rsp_ready = 1;
      cyc();
      v[1] = 0;
      chk("r032_data", int'(rsp_data), 4'b0110);
      chk("r032_id", int'(rsp_id), 1);
      rsp_ready = 0;
      v[0] = 1; op[0] = 2'b01; x[0] = 2'b11; y[0] = 2'b11;
      cyc();
      v[0] = 0;
      rst = 1; cyc(); rst = 0;
      chk("r033_valid", int'(rsp_valid), 0);
      chk("r033_data", int'(rsp_data), 0);
      chk("r033_count", int'(op_count), 0);
      v = 2'b11; op[0] = 2'b00; x[0] = 2'b11; y[0] = 2'b11; op[1] = 2'b01;
      rsp_ready = 1;
      cyc();
      chk("r033_ptr", int'(rsp_id), 0);
      chk("r021_zero", int'(rsp_data), 0);
      refresh(1);
      prev_id = rsp_id;
      for (int i = 0; i < 300; i++) begin
         cyc();
         chk("r034_alt", int'(rsp_id), int'(!prev_id));
         prev_id = rsp_id;
         refresh(1);
      end
      chk("r034_sat", int'(op_count), 255);
      rst = 1; v = 0; cyc(); rst = 0;
      for (int i = 0; i < 400; i++) begin
         rsp_ready = 1'($urandom_range(0, 1));
         refresh(0);
         cyc();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
